// File: rtl/avalon_sdr_pipe_if.sv
// Avalon-MM master bus between avalon_sdr_pipe and the SDRAM controller.
// Purely structural: no latency and no backpressure of its own (the slave stalls via waitrequest).
interface avalon_sdr_pipe_if #(
  parameter int AVM_DW = 16
) ();
  logic                  read;
  logic                  write;
  logic [31:0]           address;
  logic [AVM_DW-1:0]     writedata;
  logic [AVM_DW/8-1:0]   byteenable;
  logic [AVM_DW-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output read, write, address, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_sdr_pipe.sv
// Block mover between a flat element register file and SDRAM; bus request one cycle after start, pipelined reads.
// Backpressure: waitrequest freezes the request; at most MAX_PENDING reads in flight.
module avalon_sdr_pipe #(
  parameter int AVM_DW      = 16,
  parameter int ELEM_W      = 32,
  parameter int MAX_NELEMS  = 64,
  parameter int MAX_PENDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  avalon_sdr_pipe_if.master            avm_m0,
  input  logic [31:0]                  sdr_baseaddr,
  input  logic [29:0]                  sdr_nelems,
  output logic [ELEM_W*MAX_NELEMS-1:0] sdr_readdata,
  input  logic [ELEM_W*MAX_NELEMS-1:0] sdr_writedata,
  input  logic                         sdr_readstart,
  input  logic                         sdr_writestart,
  output logic                         sdr_readend,
  output logic                         sdr_writeend,
  output logic                         sdr_busy,
  output logic                         sdr_error,
  output logic                         sdr_clk,
  output logic                         sdr_reset
);

  localparam int          WPE   = ELEM_W / AVM_DW;
  localparam int          TMAX  = MAX_NELEMS * WPE;
  localparam int          CW    = $clog2(TMAX + 1);
  localparam int          PW    = $clog2(MAX_PENDING + 1);
  localparam int          VW    = ELEM_W * MAX_NELEMS;
  localparam logic [31:0] BSTEP = 32'(AVM_DW / 8);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DONE, S_ERR} state_t;

  state_t            state;
  logic [CW-1:0]     total;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_cnt;
  logic [PW-1:0]     pend;
  logic              rd_q;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [AVM_DW-1:0] wdat_q;
  logic [VW-1:0]     shadow;

  logic [CW-1:0]     issue_inc;
  logic [CW-1:0]     issue_nxt;
  logic [CW-1:0]     ret_inc;
  logic [PW-1:0]     pend_nxt;
  logic [VW-1:0]     shadow_nxt;
  logic              rd_acc;
  logic              rd_ret;
  logic              req_bad;

  assign avm_m0.read       = rd_q;
  assign avm_m0.write      = wr_q;
  assign avm_m0.address    = addr_q;
  assign avm_m0.writedata  = wdat_q;
  assign avm_m0.byteenable = '1;

  assign sdr_busy  = (state != S_IDLE);
  assign sdr_clk   = clk;
  assign sdr_reset = reset;

  assign rd_acc    = rd_q && !avm_m0.waitrequest;
  // Returns outside READ are stale (e.g. after a reset) and must be dropped.
  assign rd_ret    = (state == S_READ) && avm_m0.readdatavalid;
  assign issue_inc = issue_cnt + CW'(1);
  assign issue_nxt = rd_acc ? issue_inc : issue_cnt;
  assign ret_inc   = ret_cnt + CW'(1);
  assign req_bad   = (sdr_nelems == '0) || (sdr_nelems > 30'(MAX_NELEMS));

  always_comb begin
    pend_nxt = pend;
    if (rd_acc && !rd_ret) begin
      pend_nxt = pend + PW'(1);
    end else if (!rd_acc && rd_ret) begin
      pend_nxt = pend - PW'(1);
    end
  end

  always_comb begin
    shadow_nxt = shadow;
    if (rd_ret) begin
      shadow_nxt[AVM_DW*ret_cnt +: AVM_DW] = avm_m0.readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      total        <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      pend         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      shadow       <= '0;
      sdr_readdata <= '0;
      sdr_readend  <= 1'b0;
      sdr_writeend <= 1'b0;
      sdr_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sdr_writestart || sdr_readstart) begin
            total     <= CW'(sdr_nelems) * CW'(WPE);
            addr_q    <= sdr_baseaddr;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            pend      <= '0;
            if (req_bad) begin
              state        <= S_ERR;
              sdr_error    <= 1'b1;
              sdr_writeend <= sdr_writestart;
              sdr_readend  <= !sdr_writestart;
            end else if (sdr_writestart) begin
              state  <= S_WRITE;
              wr_q   <= 1'b1;
              wdat_q <= sdr_writedata[AVM_DW-1:0];
            end else begin
              state <= S_READ;
              rd_q  <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (!avm_m0.waitrequest) begin
            if (issue_inc == total) begin
              state        <= S_DONE;
              wr_q         <= 1'b0;
              sdr_writeend <= 1'b1;
            end else begin
              issue_cnt <= issue_inc;
              addr_q    <= addr_q + BSTEP;
              wdat_q    <= sdr_writedata[AVM_DW*issue_inc +: AVM_DW];
            end
          end
        end

        S_READ: begin
          issue_cnt <= issue_nxt;
          pend      <= pend_nxt;
          rd_q      <= (issue_nxt < total) && (pend_nxt < PW'(MAX_PENDING));
          if (rd_acc) begin
            addr_q <= addr_q + BSTEP;
          end
          if (rd_ret) begin
            ret_cnt <= ret_inc;
            shadow  <= shadow_nxt;
            // Publish the whole block at once so the user never sees a partial result.
            if (ret_inc == total) begin
              sdr_readdata <= shadow_nxt;
              sdr_readend  <= 1'b1;
              rd_q         <= 1'b0;
              state        <= S_DONE;
            end
          end
        end

        S_DONE, S_ERR: begin
          sdr_readend  <= 1'b0;
          sdr_writeend <= 1'b0;
          sdr_error    <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_sdr_pipe.sv
// Bench for avalon_sdr_pipe: directed and randomized transfers against an Avalon slave model with a word-level reference.
module tb_avalon_sdr_pipe;
  localparam int AVM_DW      = 16;
  localparam int ELEM_W      = 32;
  localparam int MAX_NELEMS  = 64;
  localparam int MAX_PENDING = 4;
  localparam int WPE         = ELEM_W / AVM_DW;
  localparam int VW          = ELEM_W * MAX_NELEMS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_sdr_pipe_if #(.AVM_DW(AVM_DW)) bus ();

  logic [31:0]   sdr_baseaddr;
  logic [29:0]   sdr_nelems;
  logic [VW-1:0] sdr_readdata;
  logic [VW-1:0] sdr_writedata;
  logic          sdr_readstart, sdr_writestart;
  logic          sdr_readend, sdr_writeend, sdr_busy, sdr_error, sdr_clk, sdr_reset;

  avalon_sdr_pipe #(
    .AVM_DW(AVM_DW), .ELEM_W(ELEM_W), .MAX_NELEMS(MAX_NELEMS), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset), .avm_m0(bus),
    .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
    .sdr_readdata(sdr_readdata), .sdr_writedata(sdr_writedata),
    .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
    .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend),
    .sdr_busy(sdr_busy), .sdr_error(sdr_error),
    .sdr_clk(sdr_clk), .sdr_reset(sdr_reset)
  );

  typedef struct { logic [31:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [15:0] d; int due; } rt_t;

  wr_t wlog[$];
  rt_t rq[$];
  int  cyc = 0;
  logic [15:0] salt;
  int  lat, wait_pct, stall_left;
  logic [31:0] stall_addr;
  int  n_rd_acc, n_wr_acc, n_ret, n_bus, cnt_wend, cnt_rend, cnt_err, cnt_coinc;
  int  outst, peak, same_cycle, stab_bad, rd_bad_change, hold_cnt;
  int  first_wr_cyc, first_acc_cyc, last_acc_cyc, last_end_cyc;
  logic prev_stall = 1'b0;
  logic p_rd, p_wr;
  logic [31:0] p_a;
  logic [15:0] p_d;
  logic [VW-1:0] p_rdata;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_rd;

  function automatic logic [15:0] mem(input logic [31:0] a);
    return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ salt;
  endfunction

  // Slave and monitor: decide waitrequest/returns for the cycle, log what will be accepted at the next edge.
  always @(negedge clk) begin : slave
    logic w, ret, acc_rd, acc_wr;
    int due;
    cyc++;
    if (prev_stall && (bus.read !== p_rd || bus.write !== p_wr || bus.address !== p_a ||
                       (p_wr && bus.writedata !== p_d)))
      stab_bad++;
    w = 1'b0;
    if ((bus.read === 1'b1 || bus.write === 1'b1) && bus.address === stall_addr && stall_left > 0) begin
      w = 1'b1;
      stall_left--;
    end else if (wait_pct > 0 && int'($urandom_range(99)) < wait_pct) begin
      w = 1'b1;
    end
    bus.waitrequest = w;
    ret = (rq.size() > 0) && (rq[0].due <= cyc);
    bus.readdatavalid = ret;
    bus.readdata = ret ? rq[0].d : 16'($urandom);
    if (ret) void'(rq.pop_front());
    acc_rd = (bus.read === 1'b1) && !w;
    acc_wr = (bus.write === 1'b1) && !w;
    if (bus.read === 1'b1 || bus.write === 1'b1) n_bus++;
    if (bus.write === 1'b1 && first_wr_cyc < 0) first_wr_cyc = cyc;
    if (bus.write === 1'b1 && bus.address == 32'h1002 && bus.writedata == 16'h2222) hold_cnt++;
    if (acc_wr) begin
      wlog.push_back('{bus.address, bus.writedata});
      n_wr_acc++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (acc_rd) begin
      due = cyc + lat;
      if (rq.size() > 0 && due <= rq[$].due) due = rq[$].due + 1;
      rq.push_back('{mem(bus.address), due});
      n_rd_acc++;
    end
    if (ret) n_ret++;
    if (acc_rd && ret) same_cycle++;
    outst = outst + int'(acc_rd) - int'(ret);
    if (outst > peak) peak = outst;
    if (sdr_writeend === 1'b1) cnt_wend++;
    if (sdr_readend === 1'b1) cnt_rend++;
    if (sdr_error === 1'b1) cnt_err++;
    if (sdr_error === 1'b1 && (sdr_readend === 1'b1 || sdr_writeend === 1'b1)) cnt_coinc++;
    if (sdr_writeend === 1'b1 || sdr_readend === 1'b1) last_end_cyc = cyc;
    if (!reset && sdr_readdata !== p_rdata && sdr_readend !== 1'b1) rd_bad_change++;
    prev_stall = (bus.read === 1'b1 || bus.write === 1'b1) && w;
    p_rd = bus.read; p_wr = bus.write; p_a = bus.address; p_d = bus.writedata;
    p_rdata = sdr_readdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] exp);
    checks++;
    assert (sdr_readdata === exp) else begin
      errors++;
      $error("FAIL %s: observed[127:0] %h expected[127:0] %h", tag, sdr_readdata[127:0], exp[127:0]);
    end
  endtask

  task clr;
    wlog.delete();
    n_rd_acc = 0; n_wr_acc = 0; n_ret = 0; n_bus = 0;
    cnt_wend = 0; cnt_rend = 0; cnt_err = 0; cnt_coinc = 0;
    outst = 0; peak = 0; same_cycle = 0; stab_bad = 0; rd_bad_change = 0; hold_cnt = 0;
    first_wr_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; last_end_cyc = -1;
  endtask

  task automatic run_op(input logic wr, input logic rd, input logic [31:0] base, input int n,
                        output int start_c);
    int k;
    @(negedge clk); #1;
    sdr_baseaddr = base; sdr_nelems = 30'(n);
    sdr_writestart = wr; sdr_readstart = rd;
    start_c = cyc;
    @(negedge clk); #1;
    sdr_writestart = 1'b0; sdr_readstart = 1'b0;
    k = 0;
    while (cnt_wend + cnt_rend == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("op_end_within_budget", (cnt_wend + cnt_rend) != 0, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [31:0] base, input int n);
    int bad = 0;
    if (wlog.size() != n * WPE) bad++;
    for (int k = 0; k < wlog.size() && k < n * WPE; k++) begin
      if (wlog[k].a !== base + 32'(k * (AVM_DW / 8))) bad++;
      if (wlog[k].d !== sdr_writedata[AVM_DW*k +: AVM_DW]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic model_read(input logic [31:0] base, input int n);
    for (int k = 0; k < n * WPE; k++)
      exp_rd[AVM_DW*k +: AVM_DW] = mem(base + 32'(k * (AVM_DW / 8)));
  endtask

  initial begin : stim
    int sc, k, n;
    logic op;
    logic [31:0] base;
    sdr_baseaddr = '0; sdr_nelems = '0; sdr_writedata = '0;
    sdr_readstart = 1'b0; sdr_writestart = 1'b0;
    lat = 2; wait_pct = 0; stall_left = 0; stall_addr = 32'hFFFF_FFFF;
    salt = 16'($urandom);
    exp_rd = '0;
    clr();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", bus.read, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_writedata", bus.writedata, 0);
    chk("rst_byteenable", bus.byteenable, 2'b11);
    chk("rst_ends_err_busy", {sdr_readend, sdr_writeend, sdr_error, sdr_busy}, 0);
    chk("rst_sdr_reset", sdr_reset, 1);
    chk_vec("rst_readdata", '0);
    reset = 1'b0;

    // Write, no stall
    clr();
    for (int i = 0; i < VW / 32; i++) sdr_writedata[32*i +: 32] = $urandom;
    sdr_writedata[63:0] = 64'h4444_3333_2222_1111;
    run_op(1'b1, 1'b0, 32'h1000, 2, sc);
    check_write("wr_nostall_log", 32'h1000, 2);
    chk("wr_first_req_cycle", first_wr_cyc - sc, 1);
    chk("wr_consecutive", last_acc_cyc - first_acc_cyc, 3);
    chk("wr_end_latency", last_end_cyc - sc, 5);
    chk("wr_end_pulses", {cnt_wend[7:0], cnt_rend[7:0]}, 16'h0100);
    chk("wr_busy_after", sdr_busy, 0);

    // Write with stall on word 1
    clr();
    stall_addr = 32'h1002; stall_left = 3;
    run_op(1'b1, 1'b0, 32'h1000, 2, sc);
    stall_addr = 32'hFFFF_FFFF;
    chk("stall_hold_cycles", hold_cnt, 4);
    chk("stall_accepts", n_wr_acc, 4);
    chk("stall_stability", stab_bad, 0);
    chk("stall_end_latency", last_end_cyc - sc, 8);
    chk("stall_writeend", cnt_wend, 1);
    check_write("stall_log", 32'h1000, 2);

    // Pipelined read, slave latency 5
    clr();
    lat = 5;
    run_op(1'b0, 1'b1, 32'h2000, 4, sc);
    model_read(32'h2000, 4);
    chk("rd_peak_outstanding", peak, MAX_PENDING);
    chk("rd_accepts", n_rd_acc, 8);
    chk("rd_returns", n_ret, 8);
    chk_vec("rd_data", exp_rd);
    chk("rd_data_only_at_end", rd_bad_change, 0);
    chk("rd_end_pulses", {cnt_rend[7:0], cnt_wend[7:0]}, 16'h0100);

    // Accept and return in the same cycle
    clr();
    lat = 1;
    base = $urandom;
    run_op(1'b0, 1'b1, base, 16, sc);
    model_read(base, 16);
    chk("same_cycle_seen", same_cycle > 0, 1);
    chk("same_cycle_counts", {n_rd_acc[15:0], n_ret[15:0]}, {16'd32, 16'd32});
    chk("same_cycle_peak_ok", peak <= MAX_PENDING, 1);
    chk_vec("same_cycle_data", exp_rd);

    // Range errors
    clr();
    run_op(1'b0, 1'b1, 32'h3000, 0, sc);
    chk("err0_pulses", {cnt_err[7:0], cnt_rend[7:0], cnt_wend[7:0], cnt_coinc[7:0]}, 32'h01010001);
    chk("err0_no_bus", n_bus, 0);
    chk("err0_busy_after", sdr_busy, 0);
    chk_vec("err0_rdata_held", exp_rd);
    clr();
    run_op(1'b1, 1'b0, 32'h3000, MAX_NELEMS + 1, sc);
    chk("err65_pulses", {cnt_err[7:0], cnt_rend[7:0], cnt_wend[7:0], cnt_coinc[7:0]}, 32'h01000101);
    chk("err65_no_bus", n_bus, 0);

    // Write wins over a simultaneous read
    clr();
    lat = 3;
    run_op(1'b1, 1'b1, 32'h4000, 3, sc);
    chk("prio_reads", n_rd_acc, 0);
    chk("prio_writeend", {cnt_wend[7:0], cnt_rend[7:0]}, 16'h0100);
    check_write("prio_log", 32'h4000, 3);

    // Reset mid-read with two outstanding
    clr();
    lat = 20;
    @(negedge clk); #1;
    sdr_baseaddr = 32'h5000; sdr_nelems = 30'd8; sdr_readstart = 1'b1;
    @(negedge clk); #1;
    sdr_readstart = 1'b0;
    k = 0;
    while (n_rd_acc < 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rst_mid_two_issued", n_rd_acc, 2);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    exp_rd = '0;
    chk("rst_mid_idle", {sdr_busy, bus.read}, 0);
    k = 0;
    while (rq.size() > 0 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid_late_returns", n_ret, 2);
    chk("rst_mid_no_end", cnt_rend + cnt_wend, 0);
    chk_vec("rst_mid_rdata", exp_rd);

    // Randomized transfers with random stalls and latencies
    for (int it = 0; it < 8; it++) begin
      clr();
      wait_pct = $urandom_range(0, 40);
      lat = $urandom_range(1, 8);
      n = (it == 0) ? MAX_NELEMS : int'($urandom_range(1, MAX_NELEMS));
      base = (it == 1) ? 32'hFFFF_FFF8 : $urandom;
      op = (it < 2) ? it[0] : 1'($urandom_range(0, 1));
      for (int i = 0; i < VW / 32; i++) sdr_writedata[32*i +: 32] = $urandom;
      run_op(op, !op, base, n, sc);
      chk("rnd_stability", stab_bad, 0);
      if (op) begin
        check_write("rnd_write_log", base, n);
        chk("rnd_writeend", {cnt_wend[7:0], cnt_rend[7:0]}, 16'h0100);
      end else begin
        model_read(base, n);
        chk_vec("rnd_read_data", exp_rd);
        chk("rnd_read_peak_ok", peak <= MAX_PENDING, 1);
        chk("rnd_read_counts", {n_rd_acc[15:0], n_ret[15:0]}, {16'(n * WPE), 16'(n * WPE)});
        chk("rnd_read_only_at_end", rd_bad_change, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
